// File: rtl/iot_feeder_if.sv
// Purpose : bundles the record handshake and the filter-side byte bus of iot_feeder.
// Latency : none (wires only).
// Backpressure: rec_ready toward the record source, busy from the filter.
// Ports   : rec_valid/rec_data/rec_ready (record in), fn_req (requested function),
//           busy (filter stall), in_en/iot_in (byte out), fn_sel (function out),
//           round_done (end-of-round pulse).
interface iot_feeder_if;
  logic         rec_valid;
  logic [127:0] rec_data;
  logic         rec_ready;
  logic [2:0]   fn_req;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         round_done;

  // Environment side: record source plus filter.
  modport master (
    output rec_valid, rec_data, fn_req, busy,
    input  rec_ready, in_en, iot_in, fn_sel, round_done
  );

  // Feeder side.
  modport slave (
    input  rec_valid, rec_data, fn_req, busy,
    output rec_ready, in_en, iot_in, fn_sel, round_done
  );
endinterface

// File: rtl/iot_feeder.sv
// Purpose : buffers 128-bit records and streams each as 16 MSB-first bytes to the filter.
// Latency : first byte one edge after a push into an empty FIFO; 16 cycles per record.
// Backpressure: rec_ready = !full && !rst; busy only holds off a record start at a boundary.
// Ports   : clk, rst (sync, active-high); bus (slave): rec_valid/rec_data/rec_ready,
//           fn_req, busy, in_en/iot_in, fn_sel, round_done.
module iot_feeder #(
  parameter int DEPTH          = 2,
  parameter int RECS_PER_ROUND = 8
) (
  input  logic         clk,
  input  logic         rst,
  iot_feeder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (RECS_PER_ROUND > 1) ? $clog2(RECS_PER_ROUND) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;

  // Record FIFO
  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  // Record in flight
  logic [127:0]  sreg_q, sreg_d;
  logic [3:0]    bidx_q, bidx_d;
  logic [RW-1:0] ridx_q, ridx_d;
  logic          last_q, last_d;   // record in flight closes its round

  // Registered outputs
  logic          in_en_q, in_en_d;
  logic [7:0]    iot_in_q, iot_in_d;
  logic [2:0]    fn_sel_q, fn_sel_d;
  logic          round_done_q, round_done_d;

  assign full          = (cnt_q == CW'(DEPTH));
  assign empty         = (cnt_q == '0);
  assign bus.rec_ready = !full && !rst;
  assign push          = bus.rec_valid && bus.rec_ready;

  assign bus.in_en      = in_en_q;
  assign bus.iot_in     = iot_in_q;
  assign bus.fn_sel     = fn_sel_q;
  assign bus.round_done = round_done_q;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bidx_d       = bidx_q;
    ridx_d       = ridx_q;
    last_d       = last_q;
    in_en_d      = in_en_q;
    iot_in_d     = iot_in_q;
    fn_sel_d     = fn_sel_q;
    round_done_d = 1'b0;
    pop          = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;

    if (state_q == SEND && bidx_q != 4'd15) begin
      // Mid-record: busy is deliberately ignored so the 16 bytes stay contiguous.
      iot_in_d = sreg_q[{bidx_q, 3'b000} +: 8];
      bidx_d   = bidx_q - 4'd1;
    end else begin
      // Record boundary: IDLE, or SEND with bidx wrapped to 15 after byte 0 went out.
      if (state_q == SEND) begin
        round_done_d = last_q;
      end
      if (!empty && !bus.busy) begin
        pop      = 1'b1;
        sreg_d   = mem_q[rd_ptr_q];
        iot_in_d = mem_q[rd_ptr_q][127:120];
        in_en_d  = 1'b1;
        bidx_d   = 4'd14;
        state_d  = SEND;
        last_d   = (ridx_q == RW'(RECS_PER_ROUND - 1));
        if (ridx_q == '0) begin
          fn_sel_d = bus.fn_req;
        end
        if (ridx_q == RW'(RECS_PER_ROUND - 1)) begin
          ridx_d = '0;
        end else begin
          ridx_d = ridx_q + RW'(1);
        end
      end else begin
        in_en_d = 1'b0;
        state_d = IDLE;
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.rec_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      sreg_q       <= '0;
      bidx_q       <= 4'd15;
      ridx_q       <= '0;
      last_q       <= 1'b0;
      in_en_q      <= 1'b0;
      iot_in_q     <= '0;
      fn_sel_q     <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      bidx_q       <= bidx_d;
      ridx_q       <= ridx_d;
      last_q       <= last_d;
      in_en_q      <= in_en_d;
      iot_in_q     <= iot_in_d;
      fn_sel_q     <= fn_sel_d;
      round_done_q <= round_done_d;
    end
  end

endmodule

// File: tb/tb_iot_feeder.sv
// Purpose : self-checking bench for iot_feeder against a queue-based reference model.
// Latency : n/a.
// Backpressure: bench drives rec_valid/busy; model predicts rec_ready and the byte stream.
module tb_iot_feeder;
  localparam int DEPTH = 2;
  localparam int RPR   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iot_feeder_if bus();

  iot_feeder #(.DEPTH(DEPTH), .RECS_PER_ROUND(RPR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [127:0] m_q[$];
  logic [127:0] m_cur;
  int           m_rem;      // bytes of m_cur still to present
  int           m_recs;     // records started since reset
  logic         m_en;
  logic [7:0]   m_byte;
  logic [2:0]   m_fn;
  logic         m_rd;
  logic         m_in_rst;
  logic         m_pushed;

  // Statistics gathered from DUT outputs
  int cnt_en, cnt_rd, run, max_run, cnt_notready;
  int fn_at[64];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cnt_en = 0; cnt_rd = 0; run = 0; max_run = 0; cnt_notready = 0;
    for (int i = 0; i < 64; i++) fn_at[i] = 0;
  endtask

  // Advance the model across one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit           push;
    logic [127:0] pdat;
    m_pushed = 1'b0;
    if (rst) begin
      m_q.delete();
      m_rem = 0; m_recs = 0; m_en = 1'b0; m_byte = 8'h00; m_fn = 3'd0; m_rd = 1'b0;
      m_in_rst = 1'b1;
    end else begin
      m_in_rst = 1'b0;
      push = bus.rec_valid && (m_q.size() < DEPTH);
      pdat = bus.rec_data;
      m_rd = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        m_byte = 8'(m_cur >> (8 * m_rem));
      end else begin
        if (m_en && m_recs > 0 && (m_recs % RPR) == 0) m_rd = 1'b1;
        if (m_q.size() > 0 && !bus.busy) begin
          m_cur = m_q.pop_front();
          if ((m_recs % RPR) == 0) m_fn = bus.fn_req;
          m_recs++;
          m_byte = m_cur[127:120];
          m_rem  = 15;
          m_en   = 1'b1;
        end else begin
          m_en = 1'b0;
        end
      end
      if (push) begin
        m_q.push_back(pdat);
        m_pushed = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("rec_ready", bus.rec_ready, (!rst && m_q.size() < DEPTH));
    if (!rst && !bus.rec_ready) cnt_notready++;
    @(posedge clk);
    model_edge();
    #1;
    chk("in_en", bus.in_en, m_en);
    if (m_en || m_in_rst) chk("iot_in", bus.iot_in, m_byte);
    chk("fn_sel", bus.fn_sel, m_fn);
    chk("round_done", bus.round_done, m_rd);
    if (bus.in_en) begin
      cnt_en++; run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (bus.round_done) cnt_rd++;
    if (m_recs < 64) fn_at[m_recs] = bus.fn_sel;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.rec_valid = 1'b0; bus.busy = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Push n random records with rec_valid held; optionally switch fn_req once m_recs >= sw_at.
  task automatic push_n(input int n, input int sw_at, input logic [2:0] sw_fn);
    int pushed;
    int k;
    pushed = 0; k = 0;
    bus.rec_valid = 1'b1;
    bus.rec_data  = {$urandom, $urandom, $urandom, $urandom};
    while (pushed < n && k < 2000) begin
      step();
      k++;
      if (m_pushed) begin
        pushed++;
        bus.rec_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (sw_at >= 0 && m_recs >= sw_at) bus.fn_req = sw_fn;
    end
    bus.rec_valid = 1'b0;
    chk("push_count", pushed, n);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.rec_valid = 1'b0;
    bus.rec_data  = '0;
    bus.fn_req    = 3'd1;
    bus.busy      = 1'b0;
    m_q.delete();
    m_rem = 0; m_recs = 0; m_en = 1'b0; m_byte = 8'h00; m_fn = 3'd0; m_rd = 1'b0;
    m_in_rst = 1'b1; m_pushed = 1'b0;
    clr_stats();

    // Reset values
    step();
    step();
    chk("reset_in_en", bus.in_en, 1'b0);
    chk("reset_fn_sel", bus.fn_sel, 3'd0);
    rst = 1'b0;

    // 1: single known record
    clr_stats();
    bus.fn_req    = 3'b001;
    bus.rec_valid = 1'b1;
    bus.rec_data  = 128'h0F0E0D0C0B0A09080706050403020100;
    step();
    bus.rec_valid = 1'b0;
    drain(30);
    chk("t1_en_cycles", cnt_en, 16);
    chk("t1_max_run", max_run, 16);
    chk("t1_round_done", cnt_rd, 0);
    chk("t1_fn_sel", bus.fn_sel, 3'b001);

    // 2: one full round back-to-back
    do_reset();
    clr_stats();
    bus.fn_req = 3'b010;
    push_n(8, -1, 3'd0);
    drain(60);
    chk("t2_en_cycles", cnt_en, 128);
    chk("t2_contiguous", max_run, 128);
    chk("t2_round_done", cnt_rd, 1);
    chk("t2_ready_dropped", (cnt_notready > 0), 1'b1);
    chk("t2_fn_sel", bus.fn_sel, 3'b010);

    // 3: fn_req changes mid-round
    do_reset();
    clr_stats();
    bus.fn_req = 3'd1;
    push_n(16, 4, 3'd2);
    drain(60);
    chk("t3_fn_rec7", fn_at[8], 3'd1);
    chk("t3_fn_next_round", fn_at[9], 3'd2);
    chk("t3_round_done", cnt_rd, 2);

    // 4: busy around a record boundary
    do_reset();
    clr_stats();
    push_n(2, -1, 3'd0);
    k = 0;
    while (m_rem != 3 && k < 100) begin step(); k++; end
    chk("t4_reach_rem3", (m_rem == 3), 1'b1);
    bus.busy = 1'b1;
    drain(5);
    bus.busy = 1'b0;
    drain(40);
    chk("t4_en_cycles", cnt_en, 32);
    chk("t4_gap_run", max_run, 16);

    // 5: FIFO full with a record in flight
    do_reset();
    clr_stats();
    push_n(6, -1, 3'd0);
    drain(100);
    chk("t5_ready_dropped", (cnt_notready > 0), 1'b1);
    chk("t5_en_cycles", cnt_en, 96);

    // 6: reset at byte 7 of record 5
    do_reset();
    clr_stats();
    bus.fn_req = 3'd5;
    push_n(6, -1, 3'd0);
    k = 0;
    while (!(m_recs == 6 && m_rem == 7) && k < 200) begin step(); k++; end
    chk("t6_reach_byte7", (m_recs == 6 && m_rem == 7), 1'b1);
    rst = 1'b1;
    step();
    chk("t6_in_en", bus.in_en, 1'b0);
    chk("t6_fn_sel", bus.fn_sel, 3'd0);
    rst = 1'b0;
    clr_stats();
    bus.fn_req = 3'd6;
    push_n(8, -1, 3'd0);
    drain(60);
    chk("t6_round_done", cnt_rd, 1);
    chk("t6_en_cycles", cnt_en, 128);

    // Random traffic with occasional busy and reset
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bus.rec_valid = ($urandom_range(0, 2) != 0);
      bus.rec_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.busy      = ($urandom_range(0, 3) == 0);
      bus.fn_req    = 3'($urandom_range(1, 7));
      rst           = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; bus.rec_valid = 1'b0; bus.busy = 1'b0;
    drain(60);
    chk("rand_drained_in_en", bus.in_en, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/iot_feeder.md
# iot_feeder

Upstream feeder for the IoT data-filter stage. Accepts 128-bit sensor records over a valid/ready handshake and buffers them in a small record FIFO. Serializes each record into 16 contiguous bytes, most-significant byte first, on the filter's `in_en`/`iot_in` byte interface, and groups records into rounds of 8 with a function select held constant per round. Records start only when the filter's `busy` is low.

## Interface
Parameters:
- `DEPTH`, 2: record FIFO depth in 128-bit entries (power of 2, ≥2).
- `RECS_PER_ROUND`, 8: records per round; `fn_sel` is constant across a round.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rec_valid` input 1: upstream record valid.
- `rec_data` input 128: upstream record; byte 15 = bits [127:120].
- `rec_ready` output 1: FIFO can accept a record.
- `fn_req` input 3: requested filter function (1..7), sampled at each round start.
- `busy` input 1: filter stall; sampled only at record boundaries.
- `in_en` output 1: byte valid toward filter.
- `iot_in` output 8: byte toward filter.
- `fn_sel` output 3: function select toward filter.
- `round_done` output 1: one-cycle pulse after the last byte of a round.

## Operation
- Push: a record is accepted at an edge where `rec_valid && rec_ready`. `rec_ready = !full && !rst`, derived combinationally from the registered occupancy count. A push is never accepted while full, including a full FIFO that pops in the same cycle.
- Shift register `sreg[127:0]` holds the record in flight. Byte index `bidx` is 4 bits.
- States:
  - IDLE: `in_en=0`. At an edge with FIFO non-empty and `busy==0`:
    - pop head into `sreg`;
    - `iot_in<=head[127:120]`, `in_en<=1`, `bidx<=14`;
    - go to SEND.
  - SEND: each edge, `iot_in<=sreg[8*bidx+:8]`, `bidx<=bidx-1`. At the edge after byte 0 has been presented:
    - if FIFO non-empty and `busy==0`, load the next record as in IDLE. Transmission is back-to-back with no gap.
    - else `in_en<=0` and go to IDLE.
- A started record always streams 16 consecutive cycles with `in_en=1`. `busy` is ignored mid-record because the filter restarts its byte count on any `in_en` gap.
- Round counter `ridx` runs 0..RECS_PER_ROUND-1 and increments per record loaded.
  - On loading a record with `ridx==0`, `fn_sel<=fn_req`.
  - `fn_sel` does not change at any other time.
- `round_done` is high for exactly the cycle after byte 0 of record `ridx==RECS_PER_ROUND-1` is presented. This holds whether or not the next record follows back-to-back.
- Simultaneous push and pop on a non-full FIFO: both occur and occupancy is unchanged.

## Timing
- Reset values (one edge with `rst=1`):
  - `in_en=0`, `iot_in=0`, `fn_sel=0`, `round_done=0`;
  - FIFO empty, `ridx=0`, `bidx=15`, state IDLE;
  - `rec_ready=0` while `rst` is high, and 1 in the first cycle after release.
- Latency: for a record pushed at edge E into an empty FIFO, with IDLE and `busy=0` at edge E+1:
  - `in_en` is high from edge E+1;
  - byte 15 is presented in cycle E+1..E+2, byte 0 in cycle E+16..E+17.
- Throughput: one byte per cycle. Sustained 16 cycles per record when the FIFO stays non-empty and `busy` is low at each boundary.
- `busy` high at a boundary edge:
  - `in_en` falls at that edge;
  - the next record starts at the first later edge where `busy==0` and the FIFO is non-empty.
- Reset mid-record: stream truncates at the reset edge, with `in_en=0` after it. FIFO contents and round position are discarded, and the first post-reset record starts a new round.
- `ridx` wraps from RECS_PER_ROUND-1 to 0. No extra cycle is inserted between rounds.

## Test plan
1. Single record `0x0F0E…0100` pushed after reset, `busy=0`, `fn_req=3'b001` → `in_en` high exactly 16 cycles; `iot_in` = 0x0F,0x0E,…,0x00; `fn_sel=3'b001`; no `round_done`.
2. 8 records pushed back-to-back with `rec_valid` held high, `fn_req=3'b010` → 128 contiguous `in_en` cycles; `rec_ready` drops while the FIFO is full; `round_done` pulses once, the cycle after the 128th byte.
3. `fn_req` changed from 1 to 2 during record 3 of a round → `fn_sel` stays 1 through record 7 and becomes 2 when record 0 of the next round loads.
4. `busy` pulsed high for 5 cycles mid-record → that record's 16 bytes stay contiguous. With `busy` still high at the boundary, `in_en` gap ≥1 cycle; the next record starts the edge after `busy` falls.
5. FIFO full (`DEPTH=2`) plus a record in flight, `rec_valid` high → `rec_ready=0` until the pop edge; no record lost or duplicated (scoreboard compares all bytes).
6. `rst` asserted at byte 7 of record 5 → `in_en=0`, `fn_sel=0`, `rec_ready=0` after the reset edge; the next pushed record streams from byte 15 with a new round (`round_done` after 8 more records).
